// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        MDU_WAIT
    } stall_state_t;

    // Stage indices, IF first.
    localparam int unsigned STG_IF     = 0;
    localparam int unsigned STG_ID     = 1;
    localparam int unsigned STG_EX     = 2;
    localparam int unsigned STG_MEM    = 3;
    localparam int unsigned STG_WB     = 4;
    localparam int unsigned NUM_STAGES = 5;

    // Bubble loaded by a flushed register: addi x0,x0,0 with all control bits zero.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Watchdog counter width; covers MEM_TIMEOUT up to 1023.
    localparam int unsigned WD_W = 10;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    function automatic stage_ctrl_t ctrl_run();
        stage_ctrl_t c;
        c = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

    // Everything up to MEM holds; WB receives a bubble.
    function automatic stage_ctrl_t ctrl_mem_freeze();
        stage_ctrl_t c;
        c = ctrl_run();
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_en     = 1'b0;
        c.ex_mem_en    = 1'b0;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    // Everything up to EX holds; MEM receives a bubble.
    function automatic stage_ctrl_t ctrl_mdu_freeze();
        stage_ctrl_t c;
        c = ctrl_run();
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_en     = 1'b0;
        c.ex_mem_flush = 1'b1;
        return c;
    endfunction

    // Priority evaluation once no memory stall is pending.
    function automatic stage_ctrl_t ctrl_priority(input logic mdu_start,
                                                  input logic redirect,
                                                  input logic load_use);
        stage_ctrl_t c;
        c = ctrl_run();
        if (mdu_start) begin
            c = ctrl_mdu_freeze();
        end else if (redirect) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency, so a load into x0 never stalls.
    always_comb begin
        rs1_hit    = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
        rs2_hit    = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
        load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: FSM, memory
// watchdog and saturating stall counter; stage controls are combinational.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(MEM_TIMEOUT);

    stall_state_t     state_q, state_d;
    stage_ctrl_t      ctrl;
    logic             load_use;
    logic             mem_stall;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W:0]    wd_next;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;

    hazard_unit u_hazard (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .load_use_o    (load_use)
    );

    // Stage controls and next state; a dropped mem_req counts as an ack.
    always_comb begin
        ctrl      = ctrl_run();
        state_d   = state_q;
        mem_stall = mem_req && !mem_ack;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl    = ctrl_mem_freeze();
                    state_d = MEM_WAIT;
                end else begin
                    ctrl    = ctrl_priority(ex_mdu_start, ex_redirect, load_use);
                    state_d = ex_mdu_start ? MDU_WAIT : RUN;
                end
            end
            MDU_WAIT: begin
                if (!mdu_done) begin
                    ctrl = ctrl_mdu_freeze();
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wd_next = {1'b0, wd_q} + (WD_W + 1)'(1);
    end

    // FSM state, watchdog and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != MEM_WAIT && state_d == MEM_WAIT) begin
                wd_q <= '0;
            end else if (state_q == MEM_WAIT) begin
                if (wd_next <= WD_LIMIT) begin
                    wd_q <= wd_next[WD_W-1:0];
                end
                if (wd_next >= WD_LIMIT) begin
                    timeout_q <= 1'b1;
                end
            end
            if (!ctrl.pc_en && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl with MEM_TIMEOUT=4, CNT_W=4.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = 5'd3;
    logic [4:0] id_rs2 = 5'd5;
    logic       id_uses_rs1 = 1'b1;
    logic       id_uses_rs2 = 1'b1;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rd = 5'd5;
    logic       ex_redirect = 1'b0;
    logic       ex_mdu_start = 1'b0;
    logic       mdu_done = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ack = 1'b0;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       mem_timeout;
    logic [3:0] stall_cycles;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    // Input codes: {load-use, ex_rd=0 variant, redirect, mdu_start, mdu_done, mem_req, mem_ack}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_LU   = 7'b1000000;
    localparam logic [6:0] I_RD0  = 7'b0100000;
    localparam logic [6:0] I_RED  = 7'b0010000;
    localparam logic [6:0] I_MS   = 7'b0001000;
    localparam logic [6:0] I_MD   = 7'b0000100;
    localparam logic [6:0] I_REQ  = 7'b0000010;
    localparam logic [6:0] I_ACK  = 7'b0000001;

    // Stage-control patterns: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes}
    localparam logic [8:0] P_RUN  = 9'b11111_0000;
    localparam logic [8:0] P_MEMF = 9'b00001_0001;
    localparam logic [8:0] P_MDUF = 9'b00011_0010;
    localparam logic [8:0] P_LU   = 9'b00111_0100;
    localparam logic [8:0] P_RED  = 9'b11111_1100;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .ex_mdu_start (ex_mdu_start),
        .mdu_done     (mdu_done),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input logic [8:0] p, input logic to, input logic [3:0] cnt);
        return {p, to, cnt};
    endfunction

    // Apply one cycle of inputs just after the rising edge and queue the expected response.
    task automatic step(input string nm, input logic rst_v, input logic [6:0] in_v, input logic [13:0] e);
        logic lu, rd0;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        {lu, rd0, ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ack} = in_v;
        ex_mem_read = lu;
        ex_rd       = rd0 ? 5'd0 : 5'd5;
        id_rs2      = rd0 ? 5'd0 : 5'd5;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        logic [13:0] e, act;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                       mem_timeout, stall_cycles};
                compared++;
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL %s: got %b required %b", nm, act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and load-use
        step("reset",        1'b0, I_NONE,         ev(P_RUN, 1'b0, 4'd0));
        step("lu_stall",     1'b1, I_LU,           ev(P_LU,  1'b0, 4'd0));
        step("lu_released",  1'b1, I_NONE,         ev(P_RUN, 1'b0, 4'd1));
        step("lu_rd0",       1'b1, I_LU | I_RD0,   ev(P_RUN, 1'b0, 4'd1));
        step("redir_lu",     1'b1, I_LU | I_RED,   ev(P_RED, 1'b0, 4'd1));
        step("ack_in_run",   1'b1, I_REQ | I_ACK,  ev(P_RUN, 1'b0, 4'd1));
        step("done_in_run",  1'b1, I_MD,           ev(P_RUN, 1'b0, 4'd1));

        // Memory wait of 3 cycles with a load-use hazard held in ID
        step("mem_reset",    1'b0, I_NONE,         ev(P_RUN,  1'b0, 4'd0));
        step("mem_w0",       1'b1, I_REQ | I_LU,   ev(P_MEMF, 1'b0, 4'd0));
        step("mem_w1",       1'b1, I_REQ | I_LU,   ev(P_MEMF, 1'b0, 4'd1));
        step("mem_w2",       1'b1, I_REQ | I_LU,   ev(P_MEMF, 1'b0, 4'd2));
        step("mem_exit_lu",  1'b1, I_REQ | I_ACK | I_LU, ev(P_LU, 1'b0, 4'd3));
        step("mem_after",    1'b1, I_NONE,         ev(P_RUN,  1'b0, 4'd4));

        // MDU op with redirect held throughout
        step("mdu_reset",    1'b0, I_NONE,         ev(P_RUN, 1'b0, 4'd0));
        for (int unsigned k = 0; k < 5; k++) begin
            step("mdu_wait", 1'b1, I_MS | I_RED,   ev(P_MDUF, 1'b0, 4'(k)));
        end
        step("mdu_done",     1'b1, I_MS | I_RED | I_MD, ev(P_RUN, 1'b0, 4'd5));
        step("mdu_redir",    1'b1, I_RED,          ev(P_RED, 1'b0, 4'd5));
        step("mdu_idle",     1'b1, I_NONE,         ev(P_RUN, 1'b0, 4'd5));

        // Reset in the middle of MDU_WAIT
        step("mdu2_enter",   1'b1, I_MS,           ev(P_MDUF, 1'b0, 4'd5));
        step("mdu2_wait",    1'b1, I_NONE,         ev(P_MDUF, 1'b0, 4'd6));
        step("mdu2_rst",     1'b0, I_NONE,         ev(P_RUN,  1'b0, 4'd0));
        step("mdu2_run",     1'b1, I_NONE,         ev(P_RUN,  1'b0, 4'd0));

        // Watchdog: mem_req held, no ack
        step("wd_w0",        1'b1, I_REQ,          ev(P_MEMF, 1'b0, 4'd0));
        step("wd_w1",        1'b1, I_REQ,          ev(P_MEMF, 1'b0, 4'd1));
        step("wd_w2",        1'b1, I_REQ,          ev(P_MEMF, 1'b0, 4'd2));
        step("wd_w3",        1'b1, I_REQ,          ev(P_MEMF, 1'b0, 4'd3));
        step("wd_w4",        1'b1, I_REQ,          ev(P_MEMF, 1'b0, 4'd4));
        step("wd_timeout",   1'b1, I_REQ,          ev(P_MEMF, 1'b1, 4'd5));
        step("wd_sticky",    1'b1, I_REQ,          ev(P_MEMF, 1'b1, 4'd6));
        step("wd_rst",       1'b0, I_REQ,          ev(P_MEMF, 1'b0, 4'd0));
        step("wd_run",       1'b1, I_NONE,         ev(P_RUN,  1'b0, 4'd0));
        step("wd_redir",     1'b1, I_RED,          ev(P_RED,  1'b0, 4'd0));

        // Counter saturation over 20 load-use stall cycles
        step("sat_reset",    1'b0, I_NONE,         ev(P_RUN, 1'b0, 4'd0));
        for (int unsigned k = 0; k < 20; k++) begin
            step("sat_lu",   1'b1, I_LU,           ev(P_LU, 1'b0, (k > 15) ? 4'd15 : 4'(k)));
        end
        step("sat_hold",     1'b1, I_NONE,         ev(P_RUN, 1'b0, 4'd15));

        // Drain the scoreboard with a bounded wait
        for (int unsigned w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
